// File: rtl/operand_fetch_unit.sv
// Register file read side: 8x16 regs, writeback bypass, busy-bit RAW/WAW hold, one registered output stage.
// Latency: an instruction firing at edge N is presented in cycle N+1; in_ready drops on a hazard or a stalled output.
module operand_fetch_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            rs1,
    input  logic [2:0]            rs2,
    input  logic [2:0]            rd,
    input  logic                  has_wb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] op1,
    output logic [DATA_WIDTH-1:0] op2,
    output logic [2:0]            out_rd,
    output logic                  out_has_wb,
    input  logic                  wb_en,
    input  logic [2:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [15:0]           stall_count
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [2:0]            out_rd_q, out_rd_d;
    logic                  out_has_wb_q, out_has_wb_d;
    logic [15:0]           stall_count_q, stall_count_d;

    logic [NUM_REGS-1:0]   wb_clr, iss_set, eff_busy;
    logic                  hazard, fire;
    logic [DATA_WIDTH-1:0] op1_nxt, op2_nxt;

    always_comb begin
        wb_clr = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wb_clr[i] = wb_en && (wb_rd == 3'(i));
        end
    end

    // A writeback landing this cycle resolves the hazard in this same cycle.
    always_comb begin
        eff_busy = busy_q & ~wb_clr;
        hazard   = eff_busy[rs1] | eff_busy[rs2] | (has_wb & eff_busy[rd]);
        in_ready = !hazard && (!out_valid_q || out_ready);
        fire     = in_valid && in_ready;
    end

    always_comb begin
        op1_nxt = (wb_en && wb_rd == rs1) ? wb_data : regs_q[rs1];
        op2_nxt = (wb_en && wb_rd == rs2) ? wb_data : regs_q[rs2];
    end

    // Issue set beats writeback clear so a WAW re-issue keeps the register busy.
    always_comb begin
        iss_set = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            iss_set[i] = fire && has_wb && (rd == 3'(i));
            regs_d[i]  = wb_clr[i] ? wb_data : regs_q[i];
        end
        busy_d = iss_set | eff_busy;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        out_rd_d     = out_rd_q;
        out_has_wb_d = out_has_wb_q;
        if (fire) begin
            out_valid_d  = 1'b1;
            op1_d        = op1_nxt;
            op2_d        = op2_nxt;
            out_rd_d     = rd;
            out_has_wb_d = has_wb;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (in_valid && !in_ready && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q        <= '0;
            out_valid_q   <= 1'b0;
            op1_q         <= '0;
            op2_q         <= '0;
            out_rd_q      <= '0;
            out_has_wb_q  <= 1'b0;
            stall_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            out_rd_q      <= out_rd_d;
            out_has_wb_q  <= out_has_wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign out_rd      = out_rd_q;
    assign out_has_wb  = out_has_wb_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Scoreboard bench for operand_fetch_unit: expected bundles queued at issue, checked when execute takes them.
module tb_operand_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  rs1, rs2, rd;
    logic        has_wb;
    logic        out_valid, out_ready;
    logic [15:0] op1, op2;
    logic [2:0]  out_rd;
    logic        out_has_wb;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [15:0] stall_count;

    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_stall = 0;
    logic [35:0] exp_q [$];
    logic [35:0] sb_e;
    logic [15:0] mregs [8];

    operand_fetch_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .has_wb(has_wb),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .out_rd(out_rd), .out_has_wb(out_has_wb),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference register contents, driven only from the bench's own writeback stimulus.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mregs[i] <= 16'h0;
        end else if (wb_en) begin
            mregs[wb_rd] <= wb_data;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got op1=%h op2=%h rd=%0d wb=%b, required no output", op1, op2, out_rd, out_has_wb);
            end else begin
                sb_e = exp_q.pop_front();
                if ({op1, op2, out_rd, out_has_wb} !== sb_e) begin
                    n_fail++;
                    $display("FAIL sb_bundle: got op1=%h op2=%h rd=%0d wb=%b, required op1=%h op2=%h rd=%0d wb=%b",
                             op1, op2, out_rd, out_has_wb, sb_e[35:20], sb_e[19:4], sb_e[3:1], sb_e[0]);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; has_wb = 0; rs1 = 0; rs2 = 0; rd = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d, input logic w);
        in_valid = 1; rs1 = a; rs2 = b; rd = d; has_wb = w;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #2;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        n_chk++; if (op1 !== 16'h0)          begin n_fail++; $display("FAIL rst_op1: got %h, required 0000", op1); end
        n_chk++; if (op2 !== 16'h0)          begin n_fail++; $display("FAIL rst_op2: got %h, required 0000", op2); end
        n_chk++; if (out_rd !== 3'd0)        begin n_fail++; $display("FAIL rst_out_rd: got %0d, required 0", out_rd); end
        n_chk++; if (out_has_wb !== 1'b0)    begin n_fail++; $display("FAIL rst_out_has_wb: got %b, required 0", out_has_wb); end
        n_chk++; if (stall_count !== 16'h0)  begin n_fail++; $display("FAIL rst_stall_count: got %h, required 0000", stall_count); end
        n_chk++; if (in_ready !== 1'b1)      begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        next_cycle();
        rst = 0;
    endtask

    task automatic test_first_issue();
        wb_en = 1; wb_rd = 3; wb_data = 16'h1234;
        next_cycle();
        wb_en = 0;
        issue(3, 0, 0, 0);
        exp_q.push_back({16'h1234, 16'h0000, 3'd0, 1'b0});
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_in_ready: got %b, required 1", in_ready); end
        next_cycle();
        idle();
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_out_valid: got %b, required 1", out_valid); end
        next_cycle();
    endtask

    task automatic test_bypass();
        wb_en = 1; wb_rd = 5; wb_data = 16'hBEEF;
        issue(5, 5, 1, 0);
        exp_q.push_back({16'hBEEF, 16'hBEEF, 3'd1, 1'b0});
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_in_ready: got %b, required 1", in_ready); end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_raw_stall();
        issue(0, 0, 2, 1);
        exp_q.push_back({16'h0000, 16'h0000, 3'd2, 1'b1});
        next_cycle();
        issue(2, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_in_ready[%0d]: got %b, required 0", k, in_ready); end
            n_chk++; if (stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL raw_stall_count[%0d]: got %0d, required %0d", k, stall_count, exp_stall); end
            exp_stall++;
            next_cycle();
        end
        wb_en = 1; wb_rd = 2; wb_data = 16'h00AA;
        exp_q.push_back({16'h00AA, 16'h0000, 3'd0, 1'b0});
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b, required 1", in_ready); end
        n_chk++; if (stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL raw_stall_final: got %0d, required %0d", stall_count, exp_stall); end
        next_cycle();
        wb_en = 0;
        issue(2, 2, 0, 0);
        exp_q.push_back({16'h00AA, 16'h00AA, 3'd0, 1'b0});
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_busy_cleared: got %b, required 1", in_ready); end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_waw_set_wins();
        issue(0, 0, 4, 1);
        exp_q.push_back({16'h0000, 16'h0000, 3'd4, 1'b1});
        next_cycle();
        wb_en = 1; wb_rd = 4; wb_data = 16'h4444;
        issue(0, 0, 4, 1);
        exp_q.push_back({16'h0000, 16'h0000, 3'd4, 1'b1});
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL waw_fire: got %b, required 1", in_ready); end
        next_cycle();
        wb_en = 0;
        issue(4, 0, 0, 0);
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_still_busy: got %b, required 0", in_ready); end
        exp_stall++;
        next_cycle();
        wb_en = 1; wb_rd = 4; wb_data = 16'h5555;
        exp_q.push_back({16'h5555, 16'h0000, 3'd0, 1'b0});
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release: got %b, required 1", in_ready); end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_backpressure();
        issue(3, 5, 6, 0);
        exp_q.push_back({16'h1234, 16'hBEEF, 3'd6, 1'b0});
        next_cycle();
        out_ready = 0;
        issue(0, 0, 7, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", k, in_ready); end
            n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b, required 1", k, out_valid); end
            n_chk++; if ({op1, op2, out_rd} !== {16'h1234, 16'hBEEF, 3'd6})
                begin n_fail++; $display("FAIL bp_hold[%0d]: got %h/%h/%0d, required 1234/beef/6", k, op1, op2, out_rd); end
            n_chk++; if (stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL bp_stall_count[%0d]: got %0d, required %0d", k, stall_count, exp_stall); end
            exp_stall++;
            next_cycle();
        end
        out_ready = 1;
        exp_q.push_back({16'h0000, 16'h0000, 3'd7, 1'b0});
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b, required 1", in_ready); end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] e1, e2;
        for (int k = 0; k < 16; k++) begin
            wb_en   = ($urandom_range(0, 1) == 1);
            wb_rd   = 3'($urandom_range(0, 7));
            wb_data = 16'($urandom);
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 0);
            e1 = (wb_en && wb_rd == rs1) ? wb_data : mregs[rs1];
            e2 = (wb_en && wb_rd == rs2) ? wb_data : mregs[rs2];
            exp_q.push_back({e1, e2, rd, 1'b0});
            @(negedge clk);
            n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b, required 1", k, in_ready); end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_saturation_and_reset();
        issue(0, 0, 1, 1);
        exp_q.push_back({mregs[0], mregs[0], 3'd1, 1'b1});
        next_cycle();
        issue(1, 0, 0, 0);
        repeat (65540) @(posedge clk);
        #1;
        @(negedge clk);
        n_chk++; if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stall_count: got %h, required ffff", stall_count); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_in_ready: got %b, required 0", in_ready); end
        next_cycle();
        rst = 1;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b, required 0", out_valid); end
        n_chk++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL mid_rst_stall_count: got %h, required 0000", stall_count); end
        next_cycle();
        rst = 0;
        exp_q.push_back({16'h0000, 16'h0000, 3'd0, 1'b0});
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_busy_dropped: got %b, required 1", in_ready); end
        next_cycle();
        in_valid = 0;
        wb_en = 1; wb_rd = 1; wb_data = 16'h7777;
        next_cycle();
        wb_en = 0;
        issue(1, 1, 0, 0);
        exp_q.push_back({16'h7777, 16'h7777, 3'd0, 1'b0});
        next_cycle();
        idle();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_first_issue();
        test_bypass();
        test_raw_stall();
        test_waw_set_wins();
        test_backpressure();
        test_back_to_back();
        test_saturation_and_reset();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending bundles, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
